// File: rtl/ib_router_pkg.sv
// Shared types and helpers for the ping-pong input-buffer router.
// Read-mode encoding and a width helper for derived index widths.
package ib_router_pkg;

  typedef enum logic [1:0] {
    RR = 2'b00,
    BR = 2'b01,
    RP = 2'b10,
    NE = 2'b11
  } rd_mode_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ib_bank_page.sv
// One bank of one page: BUFH rows of BUFW words.
// Single write port, combinational full-row read port.
module ib_bank_page #(
  parameter int DW   = 32,
  parameter int BUFH = 8,
  parameter int BUFW = 17,
  parameter int RW   = 3,
  parameter int CW   = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [RW-1:0]      wrow,
  input  logic [CW-1:0]      wcol,
  input  logic [DW-1:0]      wdata,
  input  logic [RW-1:0]      rrow,
  output logic [BUFW*DW-1:0] rdata
);

  logic [BUFW*DW-1:0] mem [BUFH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wrow][wcol*DW +: DW] <= wdata;
  end

  assign rdata = mem[rrow];

endmodule

// File: rtl/ib_pingpong_router.sv
// Ping-pong input buffer: sender fills one page while the
// router reads rows, banks or pixel columns from the other.
module ib_pingpong_router
  import ib_router_pkg::*;
#(
  parameter int DW     = 32,
  parameter int POY    = 3,
  parameter int POX    = 16,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 1,
  parameter int BUFH   = 8,
  localparam int BUFW  = POX*STRIDE + KSIZE/2,
  localparam int BW    = clog2_min1(POY),
  localparam int RW    = clog2_min1(BUFH),
  localparam int CW    = clog2_min1(BUFW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DW-1:0]           wr_data,
  input  logic [BW-1:0]           wr_bank,
  input  logic [RW-1:0]           wr_row,
  input  logic [CW-1:0]           wr_col,
  input  logic                    wr_last,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [1:0]              rd_mode,
  input  logic [BW-1:0]           rd_bank,
  input  logic [RW-1:0]           rd_row,
  input  logic [CW-1:0]           rd_col,
  input  logic                    rd_release,
  output logic [POY*BUFW*DW-1:0]  rd_data,
  output logic                    rd_data_valid,
  output logic                    wr_err,
  output logic                    rd_err,
  output logic [1:0]              page_full
);

  localparam int LW = BUFW*DW;

  logic       wpage;
  logic       rpage;
  logic       wr_acc;
  logic       wr_ok;
  logic       wr_en;
  logic       wr_done;
  logic       rd_acc;
  logic       rd_ok;
  logic       rel;
  logic       upd;
  logic       is_rr;
  logic       is_br;
  logic       is_rp;
  logic       is_ne;
  logic [1:0] full_n;
  rd_mode_e   mode;

  logic [LW-1:0]         page_row [2][POY];
  logic [LW-1:0]         lane_row [POY];
  logic [POY*LW-1:0]     rd_data_n;

  assign wr_ready = !page_full[wpage];
  assign rd_ready = page_full[rpage];
  assign wr_acc   = wr_valid && wr_ready;
  assign rd_acc   = rd_valid && rd_ready;

  assign wr_ok = (int'(wr_bank) < POY)
              && (int'(wr_row) < BUFH)
              && (int'(wr_col) < BUFW);

  assign wr_en   = wr_acc && wr_ok;
  assign wr_done = wr_acc && wr_last;
  assign rel     = rd_acc && rd_release;

  assign mode  = rd_mode_e'(rd_mode);
  assign is_rr = (mode == RR);
  assign is_br = (mode == BR);
  assign is_rp = (mode == RP);
  assign is_ne = (mode == NE);

  for (genvar p = 0; p < 2; p++) begin : g_page
    for (genvar b = 0; b < POY; b++) begin : g_bank
      ib_bank_page #(
        .DW   (DW),
        .BUFH (BUFH),
        .BUFW (BUFW),
        .RW   (RW),
        .CW   (CW)
      ) u_bank (
        .clk   (clk),
        .we    (wr_en && (wpage == (p == 1))
                && (int'(wr_bank) == b)),
        .wrow  (wr_row),
        .wcol  (wr_col),
        .wdata (wr_data),
        .rrow  (rd_row),
        .rdata (page_row[p][b])
      );
    end
  end

  always_comb begin
    for (int b = 0; b < POY; b++) begin
      lane_row[b] = rpage ? page_row[1][b] : page_row[0][b];
    end
  end

  always_comb begin
    rd_ok = int'(rd_row) < BUFH;
    unique case (1'b1)
      is_br:   rd_ok = rd_ok && (int'(rd_bank) < POY);
      is_rp:   rd_ok = rd_ok && (int'(rd_col) < BUFW);
      is_ne:   rd_ok = 1'b0;
      default: ;
    endcase
  end

  // Lanes/columns not selected by the mode keep their old value.
  always_comb begin
    rd_data_n = rd_data;
    upd       = 1'b0;
    for (int b = 0; b < POY; b++) begin
      for (int c = 0; c < BUFW; c++) begin
        unique case (1'b1)
          is_rr:   upd = 1'b1;
          is_br:   upd = (int'(rd_bank) == b);
          is_rp:   upd = (int'(rd_col) == c);
          default: upd = 1'b0;
        endcase
        if (upd) begin
          rd_data_n[(b*BUFW+c)*DW +: DW] =
            lane_row[b][c*DW +: DW];
        end
      end
    end
  end

  // Completion and release always hit different pages.
  always_comb begin
    full_n = page_full;
    if (wr_done) full_n[wpage] = 1'b1;
    if (rel)     full_n[rpage] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_full     <= 2'b00;
      wpage         <= 1'b0;
      rpage         <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      wr_err        <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      page_full     <= full_n;
      wr_err        <= wr_acc && !wr_ok;
      rd_data_valid <= rd_acc && rd_ok;
      rd_err        <= rd_acc && !rd_ok;
      if (wr_done)         wpage   <= !wpage;
      if (rel)             rpage   <= !rpage;
      if (rd_acc && rd_ok) rd_data <= rd_data_n;
    end
  end

endmodule

// File: tb/tb_ib_pingpong_router.sv
// Directed bench for ib_pingpong_router with a read-data
// scoreboard fed from a reference memory model.
module tb_ib_pingpong_router;

  localparam int DW   = 32;
  localparam int POY  = 3;
  localparam int BUFH = 8;
  localparam int BUFW = 17;
  localparam int LW   = BUFW*DW;
  localparam int TW   = POY*LW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [31:0]   wr_data = '0;
  logic [1:0]    wr_bank = '0;
  logic [2:0]    wr_row = '0;
  logic [4:0]    wr_col = '0;
  logic          wr_last = 1'b0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [1:0]    rd_mode = '0;
  logic [1:0]    rd_bank = '0;
  logic [2:0]    rd_row = '0;
  logic [4:0]    rd_col = '0;
  logic          rd_release = 1'b0;
  logic [TW-1:0] rd_data;
  logic          rd_data_valid;
  logic          wr_err;
  logic          rd_err;
  logic [1:0]    page_full;

  int tests = 0;
  int fails = 0;

  logic [31:0]   mem_m [2][POY][BUFH][BUFW];
  logic [TW-1:0] exp_rd = '0;
  logic [TW-1:0] sbq [$];
  logic          wp_m = 1'b0;
  logic          rp_m = 1'b0;

  ib_pingpong_router dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_bank       (wr_bank),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_last       (wr_last),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_mode       (rd_mode),
    .rd_bank       (rd_bank),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_release    (rd_release),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .wr_err        (wr_err),
    .rd_err        (rd_err),
    .page_full     (page_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag,
                          input logic [TW-1:0] exp);
    int w;
    w = 0;
    for (int i = POY*BUFW-1; i >= 0; i--) begin
      if (rd_data[i*DW +: DW] !== exp[i*DW +: DW]) w = i;
    end
    tests++;
    assert (rd_data === exp) else begin
      fails++;
      $error("FAIL %s word=%0d obs=%h exp=%h", tag, w,
             rd_data[w*DW +: DW], exp[w*DW +: DW]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_data_valid) begin
      logic [TW-1:0] e;
      tests++;
      assert (sbq.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow obs=valid exp=no_cmd");
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk_data("rd_data", e);
      end
    end
  end

  task automatic wr_beat(input int b, input int r, input int c,
                         input logic [31:0] d, input bit last);
    int n;
    wr_valid = 1'b1;
    wr_bank  = b[1:0];
    wr_row   = r[2:0];
    wr_col   = c[4:0];
    wr_data  = d;
    wr_last  = last;
    n = 0;
    while (!wr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wr_ready_wait", 64'(wr_ready), 64'(1));
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (b < POY && r < BUFH && c < BUFW)
      mem_m[wp_m][b][r][c] = d;
    else
      chk("wr_err_pulse", 64'(wr_err), 64'(1));
    if (last) wp_m = !wp_m;
  endtask

  task automatic fill(input logic [7:0] salt, input int n);
    int k;
    k = 0;
    for (int b = 0; b < POY; b++)
      for (int r = 0; r < BUFH; r++)
        for (int c = 0; c < BUFW; c++) begin
          if (k < n)
            wr_beat(b, r, c,
                    {salt, b[7:0], r[7:0], c[7:0]},
                    k == POY*BUFH*BUFW-1);
          k++;
        end
  endtask

  task automatic rd_cmd(input logic [1:0] mode, input int b,
                        input int r, input int c, input bit rel);
    bit ok;
    ok = (mode != 2'b11) && (r < BUFH)
      && (mode != 2'b01 || b < POY)
      && (mode != 2'b10 || c < BUFW);
    if (ok) begin
      for (int lb = 0; lb < POY; lb++)
        for (int lc = 0; lc < BUFW; lc++)
          if (mode == 2'b00 || (mode == 2'b01 && lb == b)
              || (mode == 2'b10 && lc == c))
            exp_rd[(lb*BUFW+lc)*DW +: DW] = mem_m[rp_m][lb][r][lc];
      sbq.push_back(exp_rd);
    end
    rd_valid   = 1'b1;
    rd_mode    = mode;
    rd_bank    = b[1:0];
    rd_row     = r[2:0];
    rd_col     = c[4:0];
    rd_release = rel;
    chk("rd_ready", 64'(rd_ready), 64'(1));
    @(posedge clk); #1;
    rd_valid   = 1'b0;
    rd_release = 1'b0;
    chk("rd_valid", 64'(rd_data_valid), 64'(ok));
    chk("rd_err", 64'(rd_err), 64'(!ok));
    if (!ok) chk_data("rd_hold", exp_rd);
    if (rel) rp_m = !rp_m;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    #1;
    exp_rd = '0;
    wp_m   = 1'b0;
    rp_m   = 1'b0;
    sbq.delete();
    chk("rst_page_full", 64'(page_full), 64'(0));
    chk("rst_rd_valid", 64'(rd_data_valid), 64'(0));
    chk("rst_wr_err", 64'(wr_err), 64'(0));
    chk("rst_rd_err", 64'(rd_err), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(1));
    chk("rst_rd_ready", 64'(rd_ready), 64'(0));
    chk_data("rst_rd_data", exp_rd);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    fill(8'h00, 408);
    chk("full_p0", 64'(page_full), 64'(2'b01));
    chk("rd_ready_p0", 64'(rd_ready), 64'(1));
    chk("wr_ready_p1", 64'(wr_ready), 64'(1));

    rd_cmd(2'b00, 0, 2, 0, 1'b0);
    @(posedge clk); #1;
    chk("valid_once", 64'(rd_data_valid), 64'(0));

    rd_cmd(2'b00, 0, 0, 0, 1'b0);
    rd_cmd(2'b01, 1, 5, 0, 1'b0);
    rd_cmd(2'b10, 0, 3, 4, 1'b0);

    rd_cmd(2'b11, 0, 1, 0, 1'b0);
    rd_cmd(2'b01, 3, 1, 0, 1'b0);
    rd_cmd(2'b10, 0, 1, 20, 1'b0);
    @(posedge clk); #1;
    chk("rd_err_clear", 64'(rd_err), 64'(0));

    fill(8'h11, 408);
    chk("full_both", 64'(page_full), 64'(2'b11));
    chk("wr_blocked", 64'(wr_ready), 64'(0));
    wr_valid = 1'b1;
    wr_bank  = 2'd0;
    wr_row   = 3'd0;
    wr_col   = 5'd0;
    wr_data  = 32'hdead_beef;
    rd_cmd(2'b00, 0, 7, 0, 1'b0);
    @(posedge clk); #1;
    chk("wr_stall", 64'(wr_ready), 64'(0));
    chk("full_stall", 64'(page_full), 64'(2'b11));
    wr_valid = 1'b0;

    rd_cmd(2'b00, 0, 1, 0, 1'b1);
    chk("rel_full", 64'(page_full), 64'(2'b10));
    chk("rel_wr_ready", 64'(wr_ready), 64'(1));
    rd_cmd(2'b00, 0, 4, 0, 1'b0);
    rd_cmd(2'b10, 0, 0, 16, 1'b0);

    wr_beat(0, 2, 17, 32'h0bad_0bad, 1'b0);
    @(posedge clk); #1;
    chk("wr_err_clear", 64'(wr_err), 64'(0));
    wr_beat(3, 0, 0, 32'h0bad_0bad, 1'b0);
    fill(8'h22, 408);
    chk("refull", 64'(page_full), 64'(2'b11));

    rd_cmd(2'b00, 0, 6, 0, 1'b1);
    chk("rel_p1", 64'(page_full), 64'(2'b01));
    rd_cmd(2'b00, 0, 2, 0, 1'b0);
    rd_cmd(2'b00, 0, 3, 0, 1'b1);
    chk("all_free", 64'(page_full), 64'(2'b00));
    chk("rd_stall", 64'(rd_ready), 64'(0));

    fill(8'h33, 100);
    do_reset();
    fill(8'h44, 408);
    rd_cmd(2'b00, 0, 5, 0, 1'b0);
    rd_cmd(2'b01, 2, 1, 0, 1'b0);
    @(posedge clk); #1;
    do_reset();

    fill(8'h55, 408);
    rd_cmd(2'b00, 0, 2, 0, 1'b0);
    rd_cmd(2'b10, 0, 7, 9, 1'b0);
    @(posedge clk); #1;

    chk("sb_drained", 64'(sbq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
